// File: rtl/display_switcher.sv
// Selects one of NUM_FUNCS function cores for the VGA pixel stream; switches land on a
// frame boundary and are followed by BLANK_FRAMES blanked frames so the picture never tears.
module display_switcher #(
  parameter int                 NUM_FUNCS    = 3,
  parameter int                 COLOR_W      = 3,
  parameter int                 ADDR_W       = 22,
  parameter int                 BLANK_FRAMES = 1,
  parameter logic [COLOR_W-1:0] BLANK_COLOR  = '0,
  parameter int                 RESET_FUNC   = 0,
  localparam int                IDX_W        = $clog2(NUM_FUNCS)
) (
  input  logic                           sysclk,
  input  logic                           rst,
  input  logic                           next_func,
  input  logic                           sel_valid,
  input  logic [IDX_W-1:0]               sel_index,
  input  logic                           frame_start,
  input  logic [ADDR_W-1:0]              pixel_addr,
  input  logic [NUM_FUNCS*COLOR_W-1:0]   func_color,
  output logic [NUM_FUNCS*ADDR_W-1:0]    func_addr,
  output logic [NUM_FUNCS-1:0]           func_reset,
  output logic [COLOR_W-1:0]             display_color,
  output logic [IDX_W-1:0]               current_function,
  output logic                           switching
);

  typedef enum logic [1:0] {ACTIVE, PENDING, BLANK} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FUNCS - 1);
  localparam logic [IDX_W-1:0] RST_IDX  = IDX_W'(RESET_FUNC);
  localparam logic [IDX_W:0]   NUM_IDX  = (IDX_W + 1)'(NUM_FUNCS);

  state_t           state;
  logic [IDX_W-1:0] target;
  logic [3:0]       blank_cnt;
  logic             sel_ok;
  logic             start_switch;
  logic [IDX_W-1:0] next_target;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  // Target after this cycle's request; in PENDING it also feeds a same-cycle commit.
  always_comb begin
    sel_ok       = sel_valid && ({1'b0, sel_index} < NUM_IDX);
    start_switch = 1'b0;
    next_target  = target;
    if (state == ACTIVE) begin
      if (sel_ok && (sel_index != current_function)) begin
        start_switch = 1'b1;
        next_target  = sel_index;
      end else if (next_func) begin
        start_switch = 1'b1;
        next_target  = wrap_inc(current_function);
      end
    end else if (state == PENDING) begin
      if (sel_ok)
        next_target = sel_index;
      else if (next_func)
        next_target = wrap_inc(target);
    end
  end

  always_comb begin
    func_addr = '0;
    func_addr[int'(current_function)*ADDR_W +: ADDR_W] = pixel_addr;
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state            <= ACTIVE;
      current_function <= RST_IDX;
      target           <= RST_IDX;
      blank_cnt        <= '0;
      display_color    <= BLANK_COLOR;
      func_reset       <= '0;
      switching        <= 1'b0;
    end else begin
      display_color <= (state == BLANK) ? BLANK_COLOR
                       : func_color[int'(current_function)*COLOR_W +: COLOR_W];
      func_reset    <= '0;
      case (state)
        ACTIVE: begin
          if (start_switch) begin
            target    <= next_target;
            state     <= PENDING;
            switching <= 1'b1;
          end
        end
        PENDING: begin
          target <= next_target;
          if (frame_start) begin
            current_function <= next_target;
            func_reset       <= NUM_FUNCS'(1) << next_target;
            blank_cnt        <= 4'(BLANK_FRAMES);
            if (BLANK_FRAMES > 0) begin
              state <= BLANK;
            end else begin
              state     <= ACTIVE;
              switching <= 1'b0;
            end
          end
        end
        BLANK: begin
          if (frame_start) begin
            blank_cnt <= blank_cnt - 1'b1;
            if (blank_cnt == 4'd1) begin
              state     <= ACTIVE;
              switching <= 1'b0;
            end
          end
        end
        default: begin
          state     <= ACTIVE;
          switching <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_switcher.sv
// Bench for display_switcher: frame-level reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_display_switcher;

  localparam int NF = 3;
  localparam int CW = 3;
  localparam int AW = 22;
  localparam int BF = 1;
  localparam int RF = 0;

  logic          sysclk = 1'b0;
  logic          rst = 1'b1;
  logic          next_func = 1'b0;
  logic          sel_valid = 1'b0;
  logic [1:0]    sel_index = '0;
  logic          frame_start = 1'b0;
  logic [AW-1:0] pixel_addr = 22'h12345;
  logic [NF*CW-1:0] func_color = {3'b101, 3'b011, 3'b110};
  logic [NF*AW-1:0] func_addr;
  logic [NF-1:0] func_reset;
  logic [CW-1:0] display_color;
  logic [1:0]    current_function;
  logic          switching;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  display_switcher #(.NUM_FUNCS(NF), .COLOR_W(CW), .ADDR_W(AW), .BLANK_FRAMES(BF),
                     .BLANK_COLOR(3'b000), .RESET_FUNC(RF)) dut (
    .sysclk(sysclk), .rst(rst), .next_func(next_func), .sel_valid(sel_valid),
    .sel_index(sel_index), .frame_start(frame_start), .pixel_addr(pixel_addr),
    .func_color(func_color), .func_addr(func_addr), .func_reset(func_reset),
    .display_color(display_color), .current_function(current_function),
    .switching(switching)
  );

  always #5 sysclk = ~sysclk;

  // Reference model: a pending flag, a target index and a count of blank frames left.
  int       m_cur, m_tgt, m_blank;
  bit       m_pend;
  logic [CW-1:0] m_color;
  logic [NF-1:0] m_freset;

  always @(posedge sysclk) begin
    if (rst) begin
      m_cur = RF; m_tgt = RF; m_pend = 0; m_blank = 0;
      m_color = 3'b000; m_freset = '0;
    end else begin
      int req;
      m_color  = (m_blank > 0) ? 3'b000 : func_color[m_cur*CW +: CW];
      m_freset = '0;
      if (m_blank > 0) begin
        if (frame_start) m_blank = m_blank - 1;
      end else begin
        req = -1;
        if (sel_valid && int'(sel_index) < NF && (m_pend || int'(sel_index) != m_cur))
          req = int'(sel_index);
        else if (next_func)
          req = ((m_pend ? m_tgt : m_cur) + 1) % NF;
        if (req >= 0) begin
          m_tgt = req;
          m_pend = 1;
        end
        if (m_pend && frame_start) begin
          m_cur = m_tgt;
          m_pend = 0;
          m_freset = NF'(1) << m_cur;
          m_blank = BF;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge sysclk) begin
    if (chk_en) begin
      logic [NF*AW-1:0] exp_addr;
      exp_addr = '0;
      for (int k = 0; k < NF; k++)
        if (k == m_cur) exp_addr[k*AW +: AW] = pixel_addr;
      chk("model display_color", display_color, m_color);
      chk("model current_function", current_function, m_cur);
      chk("model switching", switching, m_pend || (m_blank > 0));
      chk("model func_reset", func_reset, m_freset);
      chk("model func_addr", func_addr, exp_addr);
    end
  end

  // One clock cycle with the given request pulses; returns 1 time unit after the edge.
  task automatic tick(input logic nf, input logic sv, input logic [1:0] si, input logic fs);
    next_func = nf; sel_valid = sv; sel_index = si; frame_start = fs;
    @(posedge sysclk); #1;
    next_func = 0; sel_valid = 0; sel_index = '0; frame_start = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 2'd0, 0);
  endtask

  initial begin
    // T1 reset
    @(posedge sysclk); #1;
    chk_en = 1'b1;
    chk("T1 reset color", display_color, 3'b000);
    chk("T1 reset current", current_function, 2'd0);
    chk("T1 reset switching", switching, 1'b0);
    chk("T1 reset func_reset", func_reset, 3'b000);
    rst = 1'b0;
    idle(1);
    chk("T1 color func0", display_color, 3'b110);
    chk("T1 func_addr", func_addr, {22'h0, 22'h0, 22'h12345});
    tick(0, 0, 2'd0, 1);
    chk("frame_start while active", switching, 1'b0);

    // T3 deferral: next_func mid-frame
    pixel_addr = 22'h3ABCD;
    tick(1, 0, 2'd0, 0);
    chk("T3 switching", switching, 1'b1);
    idle(2);
    chk("T3 old color held", display_color, 3'b110);
    chk("T3 no early reset", func_reset, 3'b000);
    tick(0, 0, 2'd0, 1);
    chk("T3 commit func_reset", func_reset, 3'b010);
    chk("T3 commit current", current_function, 2'd1);
    idle(1);
    chk("T3 blanked", display_color, 3'b000);
    tick(0, 0, 2'd0, 1);
    idle(1);
    chk("T3 func1 color", display_color, 3'b011);
    chk("T3 switching done", switching, 1'b0);

    // T2 wrap from function 2
    tick(0, 1, 2'd2, 0);
    tick(0, 0, 2'd0, 1);
    tick(0, 0, 2'd0, 1);
    idle(1);
    chk("T2 func2 color", display_color, 3'b101);
    tick(1, 0, 2'd0, 0);
    tick(0, 0, 2'd0, 1);
    chk("T2 wrap func_reset", func_reset, 3'b001);
    chk("T2 wrap current", current_function, 2'd0);
    idle(3);
    chk("T2 blank until frame", display_color, 3'b000);
    tick(0, 0, 2'd0, 1);
    idle(1);
    chk("T2 func0 resumes", display_color, 3'b110);

    // T4 same-cycle priority, then advance within PENDING
    tick(1, 1, 2'd1, 0);
    tick(1, 0, 2'd0, 0);
    tick(0, 0, 2'd0, 1);
    chk("T4 commit current", current_function, 2'd2);
    chk("T4 commit func_reset", func_reset, 3'b100);
    tick(0, 0, 2'd0, 1);
    idle(1);
    // Three advances come back to the same function; the switch still completes.
    tick(1, 0, 2'd0, 0);
    tick(1, 0, 2'd0, 0);
    tick(1, 0, 2'd0, 1);
    chk("T4 same-target func_reset", func_reset, 3'b100);
    chk("T4 same-target switching", switching, 1'b1);
    tick(0, 0, 2'd0, 1);
    idle(1);

    // T5 invalid index, equal index, requests during BLANK
    tick(0, 1, 2'd3, 0);
    chk("T5 invalid idx no-op", switching, 1'b0);
    tick(0, 1, 2'd2, 0);
    chk("T5 equal idx no-op", switching, 1'b0);
    chk("T5 current kept", current_function, 2'd2);
    tick(1, 0, 2'd0, 0);
    tick(0, 0, 2'd0, 1);
    tick(1, 0, 2'd0, 0);
    tick(0, 1, 2'd1, 0);
    tick(0, 0, 2'd0, 1);
    idle(1);
    chk("T5 blank requests dropped", current_function, 2'd0);
    chk("T5 not switching", switching, 1'b0);
    chk("T5 color func0", display_color, 3'b110);

    // T6 reset in PENDING
    tick(1, 0, 2'd0, 0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("T6 current", current_function, 2'd0);
    chk("T6 switching", switching, 1'b0);
    tick(0, 0, 2'd0, 1);
    chk("T6 no func_reset", func_reset, 3'b000);
    chk("T6 still func0", current_function, 2'd0);
    idle(2);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
